// File: rtl/add32_pkg.sv
// Shared types and sizes for the pipelined 32-bit carry-lookahead adder.
package add32_pkg;

   localparam int DATA_W = 32;
   localparam int GRP_W  = 4;
   localparam int N_GRP  = 8;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      ADC = 2'b10,
      SBC = 2'b11
   } op_e;

   // Everything stage 2 needs to finish the add: group G/P, operands, carry-in.
   typedef struct packed {
      logic [N_GRP-1:0]  g;
      logic [N_GRP-1:0]  p;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] bx;
      logic              c0;
      op_e               op;
   } s1_t;

   // Subtract forms feed the inverted B operand into the adder.
   function automatic logic inv_b(op_e o);
      return (o == SUB) || (o == SBC);
   endfunction

   // Carry into bit 0: fixed for ADD/SUB, taken from cin for ADC/SBC.
   function automatic logic carry0(op_e o, logic ci);
      logic c;
      case (o)
         ADD:     c = 1'b0;
         SUB:     c = 1'b1;
         default: c = ci;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/add32_cla_pipe_gp4_slice.sv
// One 4-bit group of generate/propagate, positive logic.
module gp4_slice
   import add32_pkg::*;
(
   input  logic [GRP_W-1:0] a,
   input  logic [GRP_W-1:0] b,
   output logic             g,
   output logic             p
);

   logic [GRP_W-1:0] gk;
   logic [GRP_W-1:0] pk;

   assign gk = a & b;
   assign pk = a | b;

   // Group generate/propagate from the four bit-level terms.
   always_comb begin
      g = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1]) | (pk[3] & pk[2] & pk[1] & gk[0]);
      p = &pk;
   end

endmodule

// File: rtl/add32_cla_pipe.sv
// Two-stage 32-bit carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers group G/P; stage 2 resolves group carries and nibble sums.
// Optional signed-overflow output enabled by defining ADD32_OVF_FLAG_EN.
module add32_cla_pipe
   import add32_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              cin,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] sum,
   output logic              cout,
   output logic [2:0]        c8_16_24
`ifdef ADD32_OVF_FLAG_EN
   ,
   output logic              ovf
`endif
);

   op_e               op_in;
   logic [DATA_W-1:0] b_eff;
   logic              c0_in;
   logic [N_GRP-1:0]  g_grp;
   logic [N_GRP-1:0]  p_grp;

   logic              s1_valid_q, s1_valid_d;
   s1_t               s1_q, s1_d;

   logic              s2_valid_q, s2_valid_d;
   logic              s2_en;
   logic [DATA_W-1:0] sum_q, sum_d, sum_nx;
   logic              cout_q, cout_d;
   logic [2:0]        cx_q, cx_d;
   logic [N_GRP:0]    cg;
   logic              s1_op_unused;

   assign op_in = op_e'(op);

   // Effective B operand and carry-in for the selected operation.
   always_comb begin
      b_eff = inv_b(op_in) ? ~b : b;
      c0_in = carry0(op_in, cin);
   end

   for (genvar gi = 0; gi < N_GRP; gi++) begin : g_gp
      gp4_slice u_gp (
         .a (a[gi*GRP_W +: GRP_W]),
         .b (b_eff[gi*GRP_W +: GRP_W]),
         .g (g_grp[gi]),
         .p (p_grp[gi])
      );
   end

   // Stage 2 takes a new beat when empty or when its result is being drained;
   // in_ready is a function of pipeline state and out_ready only.
   assign s2_en    = ~s2_valid_q | out_ready;
   assign in_ready = ~s1_valid_q | s2_en;

   // Stage 1 next state: capture operands and group G/P on accept.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_d       = s1_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_d.g  = g_grp;
            s1_d.p  = p_grp;
            s1_d.a  = a;
            s1_d.bx = b_eff;
            s1_d.c0 = c0_in;
            s1_d.op = op_in;
         end
      end
   end

   // Stage 1 register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
      end
   end

   // The op code travels with the beat but no stage-2 result depends on it.
   assign s1_op_unused = ^s1_q.op;

   // Two-level lookahead: every group carry is a flat sum of products of
   // G/P terms and c0, so no carry ripples from group to group.
   always_comb begin
      logic acc;
      logic pt;
      acc   = 1'b0;
      pt    = 1'b0;
      cg    = '0;
      cg[0] = s1_q.c0;
      for (int i = 1; i <= N_GRP; i++) begin
         acc = 1'b0;
         for (int j = 0; j < i; j++) begin
            pt = s1_q.g[j];
            for (int k = j + 1; k < i; k++) pt = pt & s1_q.p[k];
            acc = acc | pt;
         end
         pt = s1_q.c0;
         for (int k = 0; k < i; k++) pt = pt & s1_q.p[k];
         cg[i] = acc | pt;
      end
   end

   // Nibble sums, each using its own lookahead carry.
   always_comb begin
      sum_nx = '0;
      for (int i = 0; i < N_GRP; i++) begin
         sum_nx[i*GRP_W +: GRP_W] = s1_q.a[i*GRP_W +: GRP_W] + s1_q.bx[i*GRP_W +: GRP_W]
                                  + {{(GRP_W-1){1'b0}}, cg[i]};
      end
   end

   // Stage 2 next state: results only move when the output slot is free.
   always_comb begin
      s2_valid_d = s2_valid_q;
      sum_d      = sum_q;
      cout_d     = cout_q;
      cx_d       = cx_q;
      if (s2_en) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            sum_d  = sum_nx;
            cout_d = cg[N_GRP];
            cx_d   = {cg[6], cg[4], cg[2]};
         end
      end
   end

   // Stage 2 register, drives the outputs directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         sum_q      <= '0;
         cout_q     <= 1'b0;
         cx_q       <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         sum_q      <= sum_d;
         cout_q     <= cout_d;
         cx_q       <= cx_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign c8_16_24  = cx_q;

`ifdef ADD32_OVF_FLAG_EN
   logic ovf_q, ovf_d;
   logic c31;

   // Signed overflow: carry out of bit 31 differs from carry into bit 31.
   always_comb begin
      c31   = s1_q.a[DATA_W-1] ^ s1_q.bx[DATA_W-1] ^ sum_nx[DATA_W-1];
      ovf_d = ovf_q;
      if (s2_en && s1_valid_q) ovf_d = cg[N_GRP] ^ c31;
   end

   // Overflow flag register, travels with sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: doc/add32_cla_pipe.md
ADD32_CLA_PIPE -- requirements
Module: add32_cla_pipe

Interface
REQ-001 SHALL have parameter none; widths fixed at 32-bit data, eight 4-bit groups.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand beat present.
REQ-005 in_ready  output  1  block accepts beat this cycle.
REQ-006 op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
REQ-007 a  input  32  operand A.
REQ-008 b  input  32  operand B.
REQ-009 cin  input  1  carry in (used by ADC/SBC only).
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  32  result.
REQ-013 cout  output  1  carry out of bit 31 (positive logic; for SUB/SBC 1 = no borrow).
REQ-014 c8_16_24  output  3  intermediate carries into bits 8, 16, 24.
REQ-015 ovf  output  1  signed overflow (present only with ADD32_OVF_FLAG_EN).

Function
REQ-016 Effective B' = ~b for SUB/SBC, b otherwise; carry c0 = 0 ADD, 1 SUB, cin ADC/SBC.
REQ-017 Stage 1 SHALL register per-group G[i], P[i] (i=0..7, bits 4i..4i+3, positive logic), a, B', c0, op.
REQ-018 G[i] = g3|p3g2|p3p2g1|p3p2p1g0, P[i] = p3&p2&p1&p0, with gk=a&B', pk=a|B'.
REQ-019 Stage 2 SHALL compute group carries by lookahead: C[i+1] = G[i] | P[i]&C[i] expanded two-level, C[0]=c0; cout = C[8]; c8_16_24 = {C[6],C[4],C[2]}.
REQ-020 sum = a + B' + c0 modulo 2^32, nibble sums using C[i]; registered at stage 2 output.
REQ-021 Latency: accepted beat in cycle N appears with out_valid in cycle N+2 absent backpressure.
REQ-022 Handshake: beat transfers when valid&ready; in_ready = ~s1_valid | (~s2_valid | out_ready); stage 2 loads when empty or out_ready.
REQ-023 Throughput one beat/cycle when out_ready held 1; no beat dropped or duplicated under any out_ready pattern.
REQ-024 out_valid&sum&cout SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 in_ready SHALL not depend combinationally on in_valid.
REQ-026 Simultaneous accept at input and drain at output SHALL keep both stages full.

Reset
REQ-027 rst_n low SHALL clear s1_valid, s2_valid, out_valid=0, sum=0, cout=0, c8_16_24=0, ovf=0 asynchronously.
REQ-028 Reset mid-operation SHALL discard in-flight beats; first accepted beat after release yields result 2 cycles later.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-030 Macro ADD32_OVF_FLAG_EN defined: ovf port exists, ovf = C[8]^carry-into-bit-31, registered with sum.
REQ-031 Macro undefined: ovf port and its logic absent; all other behaviour identical.

Structure
REQ-032 Package add32_pkg SHALL hold op enum (ADD,SUB,ADC,SBC), DATA_W=32, GRP_W=4, N_GRP=8.
REQ-033 Sub-module gp4_slice SHALL compute one group's G, P (instantiated 8 times in stage 1).
REQ-034 Group carry polarity positive, compatible with positive-logic 32-bit lookahead carry unit.

Verification
REQ-035 ADD a=0xFFFFFFFF b=0x00000001 -> sum=0x00000000, cout=1, c8_16_24=3'b111, ovf=0.
REQ-036 SUB a=0x00000005 b=0x00000007 -> sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
REQ-037 ADD a=0x7FFFFFFF b=0x00000001 -> sum=0x80000000, cout=0, ovf=1 (with macro).
REQ-038 ADC a=0x000000FF b=0 cin=1 -> sum=0x00000100, c8_16_24=3'b001; SBC a=0 b=0 cin=0 -> sum=0xFFFFFFFF, cout=0.
REQ-039 Stream 16 back-to-back beats, out_ready toggling 1,0,0,1 -> results in order, match reference model, hold stable while stalled.
REQ-040 Assert rst_n low with both stages full -> out_valid=0 immediately; next beat's result after exactly 2 cycles.
